// File: rtl/simd_op_issuer_if.sv
// simd_op_issuer_if
//   Bundles the rename-side op input, the SIMD ALU drive/return signals and
//   the writeback handshake of simd_op_issuer.
//   slave  : issuer view (consumes ops and ALU results, drives ALU and writeback)
//   master : environment view (rename, ALU and writeback side)
//   Signals:
//     in_valid/in_ready/in_op/in_a/in_b/in_tag  op input from rename
//     simd_en/simd_op/simd_A/simd_B            ALU drive, packed operands
//     simd_res                                 packed ALU result
//     wb_valid/wb_ready/wb_tag/wb_data         result to writeback
//     err_type                                 sticky result type error
interface simd_op_issuer_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [12:0]      in_op;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic [TAG_W-1:0] in_tag;

  logic             simd_en;
  logic [12:0]      simd_op;
  logic [67:0]      simd_A;
  logic [67:0]      simd_B;
  logic [67:0]      simd_res;

  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic [63:0]      wb_data;
  logic             err_type;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, simd_res, wb_ready,
    output in_ready, simd_en, simd_op, simd_A, simd_B,
           wb_valid, wb_tag, wb_data, err_type
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, simd_res, wb_ready,
    input  in_ready, simd_en, simd_op, simd_A, simd_B,
           wb_valid, wb_tag, wb_data, err_type
  );
endinterface

// File: rtl/simd_op_issuer.sv
// simd_op_issuer
//   Issue-side front end and writeback collector for the SIMD ALU.
//   Buffers tagged ops, packs 64-bit operands into the 68-bit register
//   format, drives the ALU one op per cycle, tracks ops in flight through the
//   fixed-latency ALU and collects tagged, unpacked results for writeback.
//   An op is issued only when a result slot is guaranteed (credit scheme), so
//   the non-stallable ALU can never overflow the result FIFO.
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : simd_op_issuer_if.slave (op input, ALU drive/return, writeback)
// Packed format: [67:66]=PTYPE_INT, [65]=0, [64:33]=hi 32, [32]=0, [31:0]=lo 32
module simd_op_issuer #(
  parameter int         TAG_W     = 4,
  parameter int         IDEPTH    = 4,
  parameter int         RDEPTH    = 4,
  parameter int         LAT       = 2,
  parameter logic [1:0] PTYPE_INT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  simd_op_issuer_if.slave bus
);

  localparam int IAW = $clog2(IDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int CW  = $clog2(RDEPTH + LAT + 1) + 1;

  localparam logic [IAW:0]  I_ONE     = (IAW+1)'(1);
  localparam logic [IAW:0]  I_DEPTH   = (IAW+1)'(IDEPTH);
  localparam logic [RAW:0]  R_ONE     = (RAW+1)'(1);
  localparam logic [CW-1:0] R_CREDITS = CW'(RDEPTH);

  typedef struct packed {
    logic [12:0]      op;
    logic [63:0]      a;
    logic [63:0]      b;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } res_t;

  function automatic logic [67:0] pack64(input logic [63:0] v);
    return {PTYPE_INT, 1'b0, v[63:32], 1'b0, v[31:0]};
  endfunction

  // ---------------- input FIFO ----------------
  op_t          ififo_q [IDEPTH];
  logic [IAW:0] iwr_q, iwr_d;
  logic [IAW:0] ird_q, ird_d;
  logic [IAW:0] icnt_d;
  logic         in_ready_q;
  logic         ipush;
  logic         ipop;
  logic         iempty;
  op_t          ihead;

  assign iempty = (iwr_q == ird_q);
  assign ihead  = ififo_q[ird_q[IAW-1:0]];
  assign ipush  = bus.in_valid & in_ready_q;
  assign iwr_d  = ipush ? iwr_q + I_ONE : iwr_q;
  assign ird_d  = ipop  ? ird_q + I_ONE : ird_q;
  assign icnt_d = iwr_d - ird_d;

  // ---------------- result FIFO pointers ----------------
  res_t         rfifo_q [RDEPTH];
  logic [RAW:0] rwr_q;
  logic [RAW:0] rrd_q;
  logic [RAW:0] rcnt;
  logic         rpush;
  logic         rpop;
  logic         rempty;
  logic         rfull;
  res_t         rhead;

  // ---------------- in-flight pipe ----------------
  logic [LAT-1:0]   pipe_vld_q;
  logic [TAG_W-1:0] pipe_tag_q [LAT];
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    used;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LAT; k++) begin
      inflight = inflight + CW'(pipe_vld_q[k]);
    end
  end

  // Results already stored plus results still inside the ALU must leave a
  // free slot, otherwise a new op could return into a full FIFO.
  assign used = inflight + CW'(rcnt);
  assign ipop = ~iempty & (used < R_CREDITS);

  // ---------------- ALU drive registers ----------------
  logic        simd_en_q;
  logic [12:0] simd_op_q;
  logic [67:0] simd_a_q;
  logic [67:0] simd_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      simd_en_q <= 1'b0;
      simd_op_q <= '0;
      simd_a_q  <= '0;
      simd_b_q  <= '0;
    end else begin
      simd_en_q <= ipop;
      if (ipop) begin
        simd_op_q <= ihead.op;
        simd_a_q  <= pack64(ihead.a);
        simd_b_q  <= pack64(ihead.b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        pipe_tag_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= ipop;
      pipe_tag_q[0] <= ihead.tag;
      for (int k = 1; k < LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_tag_q[k] <= pipe_tag_q[k-1];
      end
    end
  end

  // ---------------- result capture / writeback ----------------
  // The ALU cannot stall: whatever sits in the last pipe stage is captured now.
  assign rpush  = pipe_vld_q[LAT-1];
  assign rempty = (rwr_q == rrd_q);
  assign rfull  = (rwr_q[RAW] != rrd_q[RAW]) &&
                  (rwr_q[RAW-1:0] == rrd_q[RAW-1:0]);
  assign rpop   = ~rempty & bus.wb_ready;
  assign rcnt   = rwr_q - rrd_q;
  assign rhead  = rfifo_q[rrd_q[RAW-1:0]];

  // Storage arrays carry no reset; pointers alone define their contents.
  always_ff @(posedge clk) begin
    if (ipush) begin
      ififo_q[iwr_q[IAW-1:0]] <= {bus.in_op, bus.in_a, bus.in_b, bus.in_tag};
    end
    if (rpush) begin
      rfifo_q[rwr_q[RAW-1:0]] <= {pipe_tag_q[LAT-1],
                                  bus.simd_res[64:33], bus.simd_res[31:0]};
    end
  end

  logic err_type_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iwr_q      <= '0;
      ird_q      <= '0;
      in_ready_q <= 1'b0;
      rwr_q      <= '0;
      rrd_q      <= '0;
      err_type_q <= 1'b0;
    end else begin
      iwr_q      <= iwr_d;
      ird_q      <= ird_d;
      // Registered from the next-state count: a pop while full only frees
      // the slot for the following cycle.
      in_ready_q <= (icnt_d < I_DEPTH);
      if (rpush) begin
        rwr_q <= rwr_q + R_ONE;
      end
      if (rpop) begin
        rrd_q <= rrd_q + R_ONE;
      end
      if (rpush && (bus.simd_res[67:66] != PTYPE_INT)) begin
        err_type_q <= 1'b1;
      end
    end
  end

  // Credits make this unreachable; firing means the credit logic is broken.
  a_no_res_overflow : assert property (
    @(posedge clk) disable iff (rst) !(rpush && rfull && !rpop)
  );

  // Separator bits of the packed result carry no data.
  logic unused_res_bits;
  assign unused_res_bits = bus.simd_res[65] ^ bus.simd_res[32];

  assign bus.in_ready = in_ready_q;
  assign bus.simd_en  = simd_en_q;
  assign bus.simd_op  = simd_op_q;
  assign bus.simd_A   = simd_a_q;
  assign bus.simd_B   = simd_b_q;
  assign bus.wb_valid = ~rempty;
  assign bus.wb_tag   = rempty ? '0 : rhead.tag;
  assign bus.wb_data  = rempty ? '0 : rhead.data;
  assign bus.err_type = err_type_q;

endmodule
